// File: rtl/button_pkg.sv
// Shared types and board defaults for the button event classifier.
// State encoding is 3-bit so other conditioners can reuse it.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_GAP       = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

    localparam int LONG_CYCLES_DEF = 1000;
    localparam int GAP_CYCLES_DEF  = 250;

endpackage

// File: rtl/button_event_classifier_if.sv
// Button level in, gesture pulses out.
// master drives the level, slave is the classifier.
interface button_event_classifier_if;

    logic btn_clean;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    modport master (
        output btn_clean,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  double_press,
        input  busy
    );

    modport slave (
        input  btn_clean,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press,
        output double_press,
        output busy
    );

endinterface

// File: rtl/edge_detect.sv
// One-register edge detector for an already synchronous level.
// rise/fall are combinational from the level and its delayed copy.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_classifier.sv
// Converts a debounced button level into press/release edges
// and short, long and double press gesture pulses.
module button_event_classifier
    import button_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input logic                      clk,
    input logic                      rst_n,
    button_event_classifier_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;

    edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_clean),
        .rise  (rise),
        .fall  (fall)
    );

    // busy is only written on state changes so it tracks the new state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.short_press   <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.double_press  <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.press_pulse   <= rise;
            bus.release_pulse <= fall;
            bus.short_press   <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.double_press  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= PRESSED;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state <= WAIT_GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state          <= LONG_HELD;
                        bus.long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                WAIT_GAP: begin
                    if (rise) begin
                        state            <= SECOND_PRESSED;
                        bus.double_press <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state           <= IDLE;
                        bus.short_press <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SECOND_PRESSED: begin
                    if (fall) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// Self-checking bench: vector table, gesture corner cases and
// randomized level runs against a timestamp-based reference model.
module tb_button_event_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 5;

    typedef struct {
        logic       b;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int phase, t, t_press, t_rel;
    logic prev;
    int n_press, n_rel, n_short, n_long, n_dbl;

    button_event_classifier_if bus ();

    button_event_classifier #(
        .CNT_W       (4),
        .LONG_CYCLES (LONG),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.press_pulse, bus.release_pulse, bus.short_press,
                bus.long_press, bus.double_press, bus.busy};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Gestures judged by elapsed time since the press / release edge.
    // phase: 0 none, 1 first hold, 2 long hold, 3 gap, 4 second hold
    task automatic model(input logic b, output logic [5:0] e);
        logic r, f, s, l, d;
        r = b & ~prev;
        f = ~b & prev;
        s = 1'b0; l = 1'b0; d = 1'b0;
        t++;
        if (phase == 0) begin
            if (r) begin phase = 1; t_press = t; end
        end else if (phase == 1) begin
            if (f) begin phase = 3; t_rel = t; end
            else if (t - t_press == LONG) begin l = 1'b1; phase = 2; end
        end else if (phase == 3) begin
            if (r) begin d = 1'b1; phase = 4; end
            else if (t - t_rel == GAP) begin s = 1'b1; phase = 0; end
        end else begin
            if (f) phase = 0;
        end
        prev = b;
        e = {r, f, s, l, d, phase != 0};
    endtask

    // Called at posedge+1: drive, wait one edge, compare.
    task automatic step(input logic b);
        logic [5:0] e;
        logic [5:0] o;
        bus.btn_clean = b;
        @(posedge clk);
        #1;
        model(b, e);
        o = outs();
        chk("model", int'(o), int'(e));
        chk("excl", int'(o[3] + o[2] + o[1] <= 2'd1), 1);
        n_press += int'(o[5]);
        n_rel   += int'(o[4]);
        n_short += int'(o[3]);
        n_long  += int'(o[2]);
        n_dbl   += int'(o[1]);
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic do_reset(input logic b);
        rst_n = 1'b0;
        bus.btn_clean = b;
        #1;
        chk("reset_outs", int'(outs()), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_hold", int'(outs()), 0);
        rst_n = 1'b1;
        prev = 1'b0;
        phase = 0;
    endtask

    vec_t tbl[13];
    int sp, sl, ss, sd, sr;

    task automatic snap();
        sp = n_press; sr = n_rel; ss = n_short; sl = n_long; sd = n_dbl;
    endtask

    initial begin
        logic b;
        phase = 0; t = 0; t_press = 0; t_rel = 0; prev = 1'b0;
        n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_dbl = 0;
        bus.btn_clean = 1'b1;
        #1;

        // held through reset: first edge after release is a press
        do_reset(1'b1);
        step(1'b1);
        chk("rst_press", int'(outs()), int'(6'b100001));
        run(1'b1, 2);
        run(1'b0, 10);

        // short press as a vector table: high 3, low 10
        tbl[0] = '{1'b1, 6'b100001};
        tbl[1] = '{1'b1, 6'b000001};
        tbl[2] = '{1'b1, 6'b000001};
        tbl[3] = '{1'b0, 6'b010001};
        for (int i = 4; i < 8; i++) tbl[i] = '{1'b0, 6'b000001};
        tbl[8] = '{1'b0, 6'b001000};
        for (int i = 9; i < 13; i++) tbl[i] = '{1'b0, 6'b000000};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].b);
            chk($sformatf("tbl_%0d", i), int'(outs()), int'(tbl[i].exp));
        end

        // long press: held 12 cycles
        snap();
        run(1'b1, 12);
        run(1'b0, 8);
        chk("long_cnt", n_long - sl, 1);
        chk("long_no_short", n_short - ss, 0);
        chk("long_busy", int'(bus.busy), 0);

        // release exactly at N+8: no long, one short
        snap();
        run(1'b1, 8);
        run(1'b0, 8);
        chk("lbound_long", n_long - sl, 0);
        chk("lbound_short", n_short - ss, 1);

        // double press: high 3, low 2, high 3, low
        snap();
        run(1'b1, 3);
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 8);
        chk("dbl_cnt", n_dbl - sd, 1);
        chk("dbl_press", n_press - sp, 2);
        chk("dbl_rel", n_rel - sr, 2);
        chk("dbl_short", n_short - ss, 0);

        // second rise at R+5 still counts as double
        snap();
        run(1'b1, 3);
        run(1'b0, 5);
        run(1'b1, 2);
        run(1'b0, 8);
        chk("gap5_dbl", n_dbl - sd, 1);
        chk("gap5_short", n_short - ss, 0);

        // second rise at R+6: short, then a fresh single gesture
        snap();
        run(1'b1, 3);
        run(1'b0, 6);
        run(1'b1, 2);
        run(1'b0, 8);
        chk("gap6_dbl", n_dbl - sd, 0);
        chk("gap6_short", n_short - ss, 2);

        // reset during the gap discards the pending short press
        snap();
        run(1'b1, 3);
        run(1'b0, 2);
        do_reset(1'b0);
        run(1'b0, 10);
        chk("rstgap_short", n_short - ss, 0);

        // random level runs with occasional resets
        b = 1'b0;
        for (int k = 0; k < 250; k++) begin
            b = ~b;
            run(b, int'($urandom_range(1, 12)));
            if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Sits directly downstream of the debouncer and consumes its clean, synchronous `clean_out` level.
- Turns that level into single-cycle event pulses: press edge, release edge, short press, long press and double press.
- Feeds UI / control FSMs that need discrete button gestures instead of a level.
- Classification uses a cycle-count hold timer and an inter-press gap timer.

Parameters:
- CNT_W, 16: width of the shared hold/gap counter.
- LONG_CYCLES, 1000: cycles the button must stay held for a long press. Legal range 2..2^CNT_W-1.
- GAP_CYCLES, 250: maximum release-to-next-press gap that counts as a double press. Legal range 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- btn_clean  input  1  debounced button level from the debouncer; 1 = pressed; already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on each 0->1 transition of btn_clean.
- release_pulse  output  1  one-cycle pulse on each 1->0 transition of btn_clean.
- short_press  output  1  one-cycle pulse: single press, released before the long threshold, with no second press inside the gap window.
- long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- double_press  output  1  one-cycle pulse on the rising edge of a second press within the gap window.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs go to 0, the FSM goes to IDLE, the counter goes to 0 and btn_q goes to 0.
  - Asserting reset mid-operation discards any pending gesture; no event is emitted for it.
- Edge detection:
  - btn_q holds btn_clean registered once.
  - rise = btn_clean & ~btn_q; fall = ~btn_clean & btn_q.
- Outputs: all are registered. An event detected at edge N is high for exactly the cycle between edge N and edge N+1.
- press_pulse and release_pulse follow rise and fall in every state, independent of classification.
- Button held across reset release: because btn_q resets to 0, the first edge after rst_n deasserts raises press_pulse and starts PRESSED.
- IDLE:
  - On rise: go to PRESSED, cnt <= 0.
- PRESSED (entered at edge N):
  - Each edge with btn_clean = 1 increments cnt.
  - fall at edge N+k: go to WAIT_GAP with cnt <= 0. fall has priority over the long check at the same edge.
  - Otherwise, if cnt == LONG_CYCLES-1: long_press pulses, go to LONG_HELD. This gives long_press at edge N+LONG_CYCLES.
- LONG_HELD:
  - On fall: go to IDLE; no short_press is emitted.
- WAIT_GAP (entered at release edge R):
  - cnt increments every edge.
  - rise at edge R+k, 1 <= k <= GAP_CYCLES: double_press pulses, go to SECOND_PRESSED. rise has priority over timeout.
  - Else, if cnt == GAP_CYCLES-1: short_press pulses at edge R+GAP_CYCLES, go to IDLE.
- SECOND_PRESSED:
  - Hold duration is ignored; no long_press is emitted.
  - On fall: go to IDLE.
- A third press inside a gap is not classified separately; it starts a fresh gesture from IDLE.
- Mutual exclusion: at most one of short_press, long_press and double_press is high in any cycle.
- Counter: never wraps, because every exit compare fires before overflow given the legal parameter ranges.
- busy = (state != IDLE), registered together with the state.

Decomposition:
- Shared package button_pkg holds:
  - FSM state encoding localparams, 3-bit: IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_PRESSED.
  - Default LONG_CYCLES and GAP_CYCLES constants for the board clock.
- One sub-module, edge_detect:
  - btn_q register plus rise and fall outputs, async active-low reset.
  - Reused by other input conditioners.
- FSM, counter and output registers live in the top.

Test Plan (LONG_CYCLES = 8, GAP_CYCLES = 5, CNT_W = 4, 10 ns clock):
- Reset:
  - rst_n = 0 with btn_clean = 1 -> all outputs 0.
  - Release rst_n -> press_pulse high one cycle at the first edge; busy = 1.
- Short press:
  - Stimulus: high 3 cycles, low 10 cycles.
  - Response: press_pulse, release_pulse at release edge R, short_press exactly once at R+5; no long_press or double_press; busy drops after R+5.
- Long press:
  - Stimulus: rise at edge N, held 12 cycles, released.
  - Response: long_press once at N+8; release_pulse on release; no short_press; busy = 0 after release.
- Long boundary:
  - Stimulus: btn_clean falls exactly at N+8.
  - Response: no long_press; short_press at (N+8)+5.
- Double press:
  - Stimulus: high 3, low 2, high 3, low.
  - Response: double_press at the second rise edge; two press_pulse and two release_pulse; no short_press afterwards.
- Gap boundary and reset:
  - Second rise at R+5 -> double_press.
  - Second rise at R+6 -> short_press at R+5, then a new PRESSED gesture.
  - rst_n pulsed low in WAIT_GAP -> no short_press ever emitted.
